cpu_checker_arbiter: RTL and testbench

Shares one `cpu_checker` instance between two independent character-stream requesters. Each requester sends complete trace messages, `^...#` or `*...#`, over a valid/ready handshake. The arbiter grants one requester per message in round-robin order and forwards the chars, registered, to the checker. It drives the granted requester's `freq`, captures the checker's `format_type`/`error_code` after the terminating `#`, and returns them tagged with the source. It sits between the trace sources and `cpu_checker`, and also guards the checker against runaway messages.

---
 rtl/cpu_checker_arbiter.sv | 120 ++++++++++++
 tb/tb_cpu_checker_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_checker_arbiter.sv
// Round-robin, per-message arbiter sharing one cpu_checker between two char-stream requesters.
// Forces a terminating '#' on runaway messages and flushes the rest of that message.
module cpu_checker_arbiter #(
  parameter int MAX_LEN = 48,
  parameter int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  req0_char,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_freq,
  input  logic [7:0]  req1_char,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_freq,
  output logic [7:0]  chk_char,
  output logic [15:0] chk_freq,
  input  logic [1:0]  chk_format_type,
  input  logic [3:0]  chk_error_code,
  output logic        res_valid,
  output logic        res_src,
  output logic [1:0]  res_format_type,
  output logic [3:0]  res_error_code,
  output logic        res_timeout,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, STREAM, DRAIN, CAPTURE, FLUSH} state_t;

  localparam logic [7:0] HASH = 8'h23;

  state_t        state;
  logic          last_grant;
  logic          timeout_flag;
  logic [CW-1:0] count;

  logic          at_limit;
  logic          open;
  logic          cur_valid;
  logic [7:0]    cur_char;
  logic          accept;
  logic          next_grant;

  // last_grant doubles as the current owner once a message is in flight.
  assign cur_valid  = last_grant ? req1_valid : req0_valid;
  assign cur_char   = last_grant ? req1_char  : req0_char;
  assign at_limit   = (count == CW'(MAX_LEN));
  assign open       = ((state == STREAM) && !at_limit) || (state == FLUSH);
  assign req0_ready = open && !last_grant;
  assign req1_ready = open && last_grant;
  assign accept     = open && cur_valid;
  assign busy       = (state != IDLE);
  assign next_grant = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      chk_char        <= 8'h00;
      chk_freq        <= 16'h0000;
      res_valid       <= 1'b0;
      res_src         <= 1'b0;
      res_format_type <= 2'd0;
      res_error_code  <= 4'h0;
      res_timeout     <= 1'b0;
      last_grant      <= 1'b1;
      timeout_flag    <= 1'b0;
      count           <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          chk_char <= 8'h00;
          if (req0_valid || req1_valid) begin
            last_grant   <= next_grant;
            chk_freq     <= next_grant ? req1_freq : req0_freq;
            count        <= '0;
            timeout_flag <= 1'b0;
            state        <= STREAM;
          end
        end
        STREAM: begin
          if (at_limit) begin
            chk_char     <= HASH;
            timeout_flag <= 1'b1;
            state        <= DRAIN;
          end else if (accept) begin
            chk_char <= cur_char;
            if (cur_char == HASH) state <= DRAIN;
            else                  count <= count + CW'(1);
          end else begin
            chk_char <= 8'h00;
          end
        end
        DRAIN: begin
          chk_char <= 8'h00;
          state    <= CAPTURE;
        end
        CAPTURE: begin
          // Checker outputs settled one edge after it consumed '#'.
          res_format_type <= chk_format_type;
          res_error_code  <= chk_error_code;
          res_src         <= last_grant;
          res_timeout     <= timeout_flag;
          res_valid       <= 1'b1;
          state           <= timeout_flag ? FLUSH : IDLE;
        end
        FLUSH: begin
          chk_char <= 8'h00;
          if (accept && (cur_char == HASH)) begin
            timeout_flag <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_checker_arbiter.sv
// Directed bench for cpu_checker_arbiter with a freq-keyed checker stub.
module tb_cpu_checker_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  req0_char, req1_char;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_freq, req1_freq;
  logic [7:0]  chk_char;
  logic [15:0] chk_freq;
  logic [1:0]  stub_fmt;
  logic [3:0]  stub_err;
  logic        res_valid, res_src, res_timeout, busy;
  logic [1:0]  res_format_type;
  logic [3:0]  res_error_code;

  int n_checks = 0;
  int n_fail   = 0;
  logic       prev_rv = 1'b0;
  logic [7:0] res_log[$];
  logic [7:0] exp_r0, exp_r1, exp_r0f4;

  always #5 clk = ~clk;

  cpu_checker_arbiter #(.MAX_LEN(48)) dut (
    .clk(clk), .reset(reset),
    .req0_char(req0_char), .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_freq(req0_freq),
    .req1_char(req1_char), .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_freq(req1_freq),
    .chk_char(chk_char), .chk_freq(chk_freq),
    .chk_format_type(stub_fmt), .chk_error_code(stub_err),
    .res_valid(res_valid), .res_src(res_src), .res_format_type(res_format_type),
    .res_error_code(res_error_code), .res_timeout(res_timeout), .busy(busy)
  );

  // Checker stand-in: latches a result keyed on freq when it consumes '#'.
  always @(posedge clk) begin
    if (reset) begin
      stub_fmt <= 2'd0;
      stub_err <= 4'h0;
    end else if (chk_char == 8'h23) begin
      case (chk_freq)
        16'd8:   begin stub_fmt <= 2'd1; stub_err <= 4'h0; end
        16'd10:  begin stub_fmt <= 2'd2; stub_err <= 4'h5; end
        16'd4:   begin stub_fmt <= 2'd2; stub_err <= 4'h0; end
        default: begin stub_fmt <= 2'd3; stub_err <= 4'hF; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (res_valid) begin
      res_log.push_back({res_src, res_timeout, res_format_type, res_error_code});
      n_checks++;
      assert (!prev_rv) else begin
        n_fail++;
        $error("FAIL res_valid_pulse: observed 2 consecutive cycles expected 1");
      end
    end
    if (req0_ready || req1_ready) begin
      n_checks++;
      assert (!(req0_ready && req1_ready)) else begin
        n_fail++;
        $error("FAIL ready_exclusive: observed both ready expected one");
      end
    end
    prev_rv <= res_valid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input bit r);
    return r ? req1_ready : req0_ready;
  endfunction

  task automatic drive(input bit r, input logic [7:0] c, input logic [15:0] f);
    if (r) begin req1_char = c; req1_freq = f; req1_valid = 1'b1; end
    else   begin req0_char = c; req0_freq = f; req0_valid = 1'b1; end
  endtask

  // Waits (bounded) for ready, then lets the next edge accept the held char.
  task automatic accept_one(input bit r);
    int cnt = 0;
    while (!rdy(r) && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_checks++;
    assert (rdy(r)) else begin
      n_fail++;
      $error("FAIL accept_wait: requester %0d ready observed 0 expected 1", r);
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input bit r, input string s, input logic [15:0] f);
    for (int i = 0; i < s.len(); i++) begin
      drive(r, s[i], f);
      accept_one(r);
      check("stream_char", 32'(chk_char), 32'(s[i]));
      check("stream_freq", 32'(chk_freq), 32'(f));
    end
    if (r) req1_valid = 1'b0;
    else   req0_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_char = 8'h00; req1_char = 8'h00;
    req0_freq = 16'h0; req1_freq = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    exp_r0   = {1'b0, 1'b0, 2'd1, 4'h0};
    exp_r1   = {1'b1, 1'b0, 2'd2, 4'h5};
    exp_r0f4 = {1'b0, 1'b0, 2'd2, 4'h0};

    // Reset values
    do_reset();
    check("rst_busy", 32'(busy), 0);
    check("rst_chk_char", 32'(chk_char), 0);
    check("rst_chk_freq", 32'(chk_freq), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_fields", 32'({res_src, res_timeout, res_format_type, res_error_code}), 0);
    check("rst_ready", 32'({req0_ready, req1_ready}), 0);

    // 1: single message from req0, result timing
    send(0, "^16@00003000: $1 <= 0#", 16'd8);
    check("t1_rv_e0", 32'(res_valid), 0);
    @(posedge clk); #1;
    check("t1_rv_e1", 32'(res_valid), 0);
    check("t1_busy_drain", 32'(busy), 1);
    @(posedge clk); #1;
    check("t1_rv_e2", 32'(res_valid), 1);
    check("t1_src", 32'(res_src), 0);
    check("t1_fmt", 32'(res_format_type), 1);
    check("t1_err", 32'(res_error_code), 0);
    check("t1_timeout", 32'(res_timeout), 0);
    @(posedge clk); #1;
    check("t1_rv_e3", 32'(res_valid), 0);
    check("t1_busy_idle", 32'(busy), 0);
    check("t1_hold_fmt", 32'(res_format_type), 1);

    // 2: both requesters contend continuously
    do_reset();
    res_log.delete();
    fork
      begin send(0, "^1@0#", 16'd8); send(0, "^1@0#", 16'd8); end
      begin send(1, "*0 <= 0#", 16'd10); send(1, "*0 <= 0#", 16'd10); end
    join
    repeat (4) @(posedge clk);
    #1;
    check("t2_count", 32'(res_log.size()), 4);
    if (res_log.size() == 4) begin
      check("t2_res0", 32'(res_log[0]), 32'(exp_r0));
      check("t2_res1", 32'(res_log[1]), 32'(exp_r1));
      check("t2_res2", 32'(res_log[2]), 32'(exp_r0));
      check("t2_res3", 32'(res_log[3]), 32'(exp_r1));
    end

    // 3: runaway message from req1
    do_reset();
    drive(1, "a", 16'd10);
    for (int i = 0; i < 48; i++) accept_one(1);
    check("t3_last_char", 32'(chk_char), 32'("a"));
    check("t3_ready_limit", 32'(req1_ready), 0);
    @(posedge clk); #1;
    check("t3_inject_hash", 32'(chk_char), 32'h23);
    check("t3_ready_drain", 32'(req1_ready), 0);
    @(posedge clk); #1;
    check("t3_drain_zero", 32'(chk_char), 0);
    @(posedge clk); #1;
    check("t3_rv", 32'(res_valid), 1);
    check("t3_timeout", 32'(res_timeout), 1);
    check("t3_src", 32'(res_src), 1);
    check("t3_result", 32'({res_format_type, res_error_code}), 32'({2'd2, 4'h5}));
    check("t3_flush_ready", 32'(req1_ready), 1);
    for (int i = 0; i < 12; i++) begin
      accept_one(1);
      check("t3_flush_char", 32'(chk_char), 0);
    end
    drive(1, 8'h23, 16'd10);
    accept_one(1);
    check("t3_flush_done", 32'(busy), 0);
    check("t3_no_extra_res", 32'(res_valid), 0);
    drive(0, "^", 16'd8);
    drive(1, "^", 16'd10);
    @(posedge clk); #1;
    check("t3_next_grant", 32'({req0_ready, req1_ready}), 32'(2'b10));
    check("t3_next_freq", 32'(chk_freq), 8);

    // 4: reset mid-message
    do_reset();
    res_log.delete();
    begin
      string m = "^16@000030";
      for (int i = 0; i < 10; i++) begin
        drive(0, m[i], 16'd8);
        accept_one(0);
      end
    end
    check("t4_busy_mid", 32'(busy), 1);
    reset = 1'b1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t4_busy", 32'(busy), 0);
    check("t4_chk_char", 32'(chk_char), 0);
    check("t4_ready", 32'({req0_ready, req1_ready}), 0);
    check("t4_rv", 32'(res_valid), 0);
    repeat (5) @(posedge clk);
    #1;
    check("t4_no_result", 32'(res_log.size()), 0);
    drive(0, "^", 16'd8);
    drive(1, "^", 16'd10);
    @(posedge clk); #1;
    check("t4_req0_wins", 32'({req0_ready, req1_ready}), 32'(2'b10));

    // 5: chk_freq switches only at the grant edge
    do_reset();
    res_log.delete();
    fork
      begin
        send(0, "*00003000 <= 0#", 16'd4);
        repeat (2) @(posedge clk);
        #1;
        check("t5_freq_idle", 32'(chk_freq), 4);
        check("t5_busy_idle", 32'(busy), 0);
        @(posedge clk); #1;
        check("t5_freq_grant", 32'(chk_freq), 10);
        check("t5_req1_ready", 32'(req1_ready), 1);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        send(1, "^1@0: $1 <= 0#", 16'd10);
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check("t5_count", 32'(res_log.size()), 2);
    if (res_log.size() == 2) begin
      check("t5_res0", 32'(res_log[0]), 32'(exp_r0f4));
      check("t5_res1", 32'(res_log[1]), 32'(exp_r1));
    end

    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
